onehot_encoder_seq: RTL and testbench

Sequential encoder that converts a signed WIDTH-bit result into a 2·LEN-bit code split into two LEN-bit halves {B,A}, the inverse of the ALU's one-hot decode and leading-ones count operations. An iterative shifter builds the code one position per clock under an FSM with a start/busy/done handshake. It sits after the ALU result mux and regenerates operand-format vectors for the one-hot and leading-ones paths.

---
 rtl/onehot_encoder_seq.sv | 125 ++++++++++++
 tb/tb_onehot_encoder_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_seq.sv
// Iterative encoder: signed n -> 2*LEN-bit one-hot (mode 0) or MSB-first leading-ones (mode 1) code.
// Valid n completes in n+2 cycles, negative/out-of-range n in 1 cycle; i_start is ignored while busy.
module onehot_encoder_seq #(
    parameter int LEN   = 8,
    parameter int WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_y,
    output logic [LEN-1:0]   o_a_oh,
    output logic [LEN-1:0]   o_b_oh,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overflow,
    output logic             o_err
);

    localparam int          CW     = 2 * LEN;
    localparam logic [31:0] CW_MAX = 32'(CW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]     shreg_q, shreg_d;
    logic [CW-1:0]     code_q, code_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;

    logic [31:0]       y_ext;
    logic              y_neg;
    logic              y_big;

    // Range check on the sign-extended value so no high bits of n are lost.
    always_comb begin
        y_ext = {{(32-WIDTH){i_y[WIDTH-1]}}, i_y};
        y_neg = i_y[WIDTH-1];
        y_big = (y_ext > CW_MAX);
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        code_d  = code_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    mode_d = i_mode;
                    if (y_neg) begin
                        err_d   = 1'b1;
                        ovf_d   = 1'b0;
                        code_d  = '0;
                        state_d = S_DONE;
                    end else if (y_big) begin
                        err_d   = 1'b0;
                        ovf_d   = 1'b1;
                        code_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = i_y;
                        shreg_d = i_mode ? '0 : CW'(1);
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    // Mode 1 fills ones in from the MSB end.
                    shreg_d = mode_q ? {1'b1, shreg_q[CW-1:1]} : {shreg_q[CW-2:0], 1'b0};
                    cnt_d   = cnt_q - WIDTH'(1);
                end else begin
                    code_d  = shreg_q;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            shreg_q <= '0;
            code_q  <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign o_a_oh     = code_q[LEN-1:0];
    assign o_b_oh     = code_q[CW-1:LEN];
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = (state_q == S_DONE);
    assign o_overflow = ovf_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// Scoreboarded bench: LEN=8 and LEN=4 instances, random stimulus, model from arithmetic on n.
module tb_onehot_encoder_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, mode8, start4, mode4;
    logic [4:0] y8, y4;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;
    logic       busy8, done8, ovf8, err8;
    logic       busy4, done4, ovf4, err4;

    onehot_encoder_seq #(.LEN(8), .WIDTH(5)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start8), .i_mode(mode8), .i_y(y8),
        .o_a_oh(a8), .o_b_oh(b8), .o_busy(busy8), .o_done(done8),
        .o_overflow(ovf8), .o_err(err8)
    );

    onehot_encoder_seq #(.LEN(4), .WIDTH(5)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start4), .i_mode(mode4), .i_y(y4),
        .o_a_oh(a4), .o_b_oh(b4), .o_busy(busy4), .o_done(done4),
        .o_overflow(ovf4), .o_err(err4)
    );

    typedef struct {
        int         n;
        bit         mode;
        bit [15:0]  code;
        bit         ovf;
        bit         err;
        int         done_cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: code is 1<<n (mode 0) or the top n bits of a 2*len vector (mode 1).
    function automatic exp_t model(input int n, input bit mode, input int len, input int issue_cyc);
        exp_t        e;
        int          w;
        bit   [31:0] t;
        w      = 2 * len;
        e.n    = n;
        e.mode = mode;
        e.code = '0;
        e.ovf  = 1'b0;
        e.err  = 1'b0;
        if (n < 0) begin
            e.err      = 1'b1;
            e.done_cyc = issue_cyc + 1;
        end else if (n > w - 1) begin
            e.ovf      = 1'b1;
            e.done_cyc = issue_cyc + 1;
        end else begin
            if (!mode) t = 32'd1 << n;
            else       t = ((32'd1 << n) - 32'd1) << (w - n);
            e.code     = t[15:0];
            e.done_cyc = issue_cyc + n + 2;
        end
        return e;
    endfunction

    function automatic int decode(input logic [15:0] c, input int len, input bit mode);
        int w;
        int cnt;
        int pos;
        w   = 2 * len;
        cnt = 0;
        pos = -1;
        if (!mode) begin
            for (int i = 0; i < w; i++) begin
                if (c[i]) begin
                    cnt++;
                    pos = i;
                end
            end
            return (cnt == 1) ? pos : -1;
        end
        for (int i = w - 1; i >= 0; i--) begin
            if (c[i]) cnt++;
            else break;
        end
        return cnt;
    endfunction

    task automatic compare(input exp_t e, input logic [15:0] code, input logic ovf,
                           input logic err, input logic busy, input int len, input string tag);
        chk({tag, "_code"},     {16'd0, code}, {16'd0, e.code});
        chk({tag, "_overflow"}, {31'd0, ovf},  {31'd0, e.ovf});
        chk({tag, "_err"},      {31'd0, err},  {31'd0, e.err});
        chk({tag, "_latency"},  cyc,           e.done_cyc);
        chk({tag, "_busy_with_done"}, {31'd0, busy}, 32'd1);
        if (!e.ovf && !e.err)
            chk({tag, "_decode"}, decode(code, len, e.mode), e.n);
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents o_done.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done8) begin
                if (q8.size() == 0) chk("dut8_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = q8.pop_front();
                    compare(e, {b8, a8}, ovf8, err8, busy8, 8, "dut8");
                end
            end
            if (done4) begin
                if (q4.size() == 0) chk("dut4_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = q4.pop_front();
                    compare(e, {8'd0, b4, a4}, ovf4, err4, busy4, 4, "dut4");
                end
            end
        end
    end

    // Called at a negedge. Waits for idle, issues one request, then optionally
    // sprays ignored starts with random operands until the DUT is idle again.
    task automatic issue(input int sel, input logic [4:0] y, input bit mode, input bit noisy);
        int n;
        int guard;
        n     = $signed(y);
        guard = 0;
        while (((sel == 8) ? busy8 : busy4) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("wait_idle_timeout", 32'd1, 32'd0);
        if (sel == 8) begin
            y8 = y; mode8 = mode; start8 = 1'b1;
            q8.push_back(model(n, mode, 8, cyc));
        end else begin
            y4 = y; mode4 = mode; start4 = 1'b1;
            q4.push_back(model(n, mode, 4, cyc));
        end
        @(negedge clk);
        guard = 0;
        while (((sel == 8) ? busy8 : busy4) && guard < 100) begin
            if (sel == 8) begin
                start8 = noisy && ($urandom_range(0, 1) == 0);
                y8     = 5'($urandom);
                mode8  = 1'($urandom);
            end else begin
                start4 = noisy && ($urandom_range(0, 1) == 0);
                y4     = 5'($urandom);
                mode4  = 1'($urandom);
            end
            @(negedge clk);
            guard++;
        end
        start8 = 1'b0;
        start4 = 1'b0;
        if (guard >= 100) chk("done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start8 = 1'b0; mode8 = 1'b0; y8 = '0;
        start4 = 1'b0; mode4 = 1'b0; y4 = '0;
        repeat (3) @(negedge clk);
        chk("rst_a8", {24'd0, a8}, 32'd0);
        chk("rst_b8", {24'd0, b8}, 32'd0);
        chk("rst_busy8", {31'd0, busy8}, 32'd0);
        chk("rst_done8", {31'd0, done8}, 32'd0);
        chk("rst_ovf8", {31'd0, ovf8}, 32'd0);
        chk("rst_err8", {31'd0, err8}, 32'd0);
        chk("rst_code4", {24'd0, b4, a4}, 32'd0);
        chk("rst_flags4", {29'd0, busy4, done4, ovf4, err4}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy8", {31'd0, busy8}, 32'd0);
        chk("idle_done8", {31'd0, done8}, 32'd0);

        // Directed cases on LEN=8
        issue(8, 5'd0,  1'b0, 1'b0);
        issue(8, 5'd11, 1'b0, 1'b0);
        issue(8, 5'd3,  1'b1, 1'b0);
        issue(8, 5'd10, 1'b1, 1'b0);
        issue(8, 5'd0,  1'b1, 1'b0);
        issue(8, 5'h1F, 1'b0, 1'b0);
        issue(8, 5'd15, 1'b1, 1'b0);
        issue(8, 5'h10, 1'b1, 1'b0);
        // Starts during RUN and DONE must be ignored
        issue(8, 5'd5,  1'b0, 1'b1);
        issue(8, 5'd7,  1'b1, 1'b1);

        // LEN=4: overflow boundary and error paths
        issue(4, 5'd9,  1'b0, 1'b0);
        issue(4, 5'd8,  1'b1, 1'b0);
        issue(4, 5'd7,  1'b1, 1'b0);
        issue(4, 5'd7,  1'b0, 1'b0);
        issue(4, 5'd15, 1'b0, 1'b1);
        issue(4, 5'h1D, 1'b1, 1'b0);
        issue(4, 5'd3,  1'b0, 1'b1);

        // Back-to-back sweep
        for (int m = 0; m < 2; m++)
            for (int n = 0; n < 16; n++)
                issue(8, 5'(n), 1'(m), 1'($urandom));

        for (int i = 0; i < 40; i++)
            issue(8, 5'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 25; i++)
            issue(4, 5'($urandom), 1'($urandom), 1'($urandom));

        // Asynchronous reset in the middle of RUN: result discarded, no o_done
        y8 = 5'd12; mode8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun_busy8", {31'd0, busy8}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_code8", {16'd0, b8, a8}, 32'd0);
        chk("midrun_rst_flags8", {28'd0, busy8, done8, ovf8, err8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrun_no_done_busy8", {31'd0, busy8}, 32'd0);

        issue(8, 5'd2, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        chk("drain_q8", q8.size(), 32'd0);
        chk("drain_q4", q4.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
